// File: rtl/reg_bank_arbiter.sv
`default_nettype none
// ============================================================================
// Module : reg_bank_arbiter
// Shared config/status register bank with SPI/I2C 4-phase req/ack arbitration.
// Rev    : 1.0
// ============================================================================
module reg_bank_arbiter #(
  parameter int NUM_CFG    = 8,
  parameter int NUM_STATUS = 8,
  parameter int REG_WIDTH  = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            ena,
  input  logic [1:0]                      sel,
  input  logic                            spi_req,
  input  logic                            spi_we,
  input  logic [ADDR_WIDTH-1:0]           spi_addr,
  input  logic [REG_WIDTH-1:0]            spi_wdata,
  output logic                            spi_ack,
  output logic [REG_WIDTH-1:0]            spi_rdata,
  input  logic                            i2c_req,
  input  logic                            i2c_we,
  input  logic [ADDR_WIDTH-1:0]           i2c_addr,
  input  logic [REG_WIDTH-1:0]            i2c_wdata,
  output logic                            i2c_ack,
  output logic [REG_WIDTH-1:0]            i2c_rdata,
  input  logic [NUM_STATUS*REG_WIDTH-1:0] status_regs,
  output logic [NUM_CFG*REG_WIDTH-1:0]    config_regs,
  output logic                            busy
);

  localparam int IDX_W    = ADDR_WIDTH - 1;
  localparam int IDX_SPAN = 1 << IDX_W;
  localparam int CFG_VIS  = (NUM_CFG < IDX_SPAN) ? NUM_CFG : IDX_SPAN;
  localparam int ST_VIS   = (NUM_STATUS < IDX_SPAN) ? NUM_STATUS : IDX_SPAN;

  // Port identifiers used for the grantee and round-robin history.
  localparam logic PORT_SPI = 1'b0;
  localparam logic PORT_I2C = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_ACK    = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic                  rr_last_q, rr_last_d;
  logic                  gnt_q, gnt_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [REG_WIDTH-1:0]  wdata_q, wdata_d;
  logic                  spi_ack_q, spi_ack_d;
  logic                  i2c_ack_q, i2c_ack_d;
  logic [REG_WIDTH-1:0]  spi_rdata_q, spi_rdata_d;
  logic [REG_WIDTH-1:0]  i2c_rdata_q, i2c_rdata_d;
  logic [REG_WIDTH-1:0]  cfg_q [NUM_CFG];
  logic [REG_WIDTH-1:0]  cfg_d [NUM_CFG];

  logic                  spi_cand;
  logic                  i2c_cand;
  logic                  gnt_req;
  logic                  gnt_ack;
  logic [IDX_W-1:0]      idx;
  logic [REG_WIDTH-1:0]  rd_val;

  assign spi_cand = spi_req && ((sel == 2'b00) || sel[1]);
  assign i2c_cand = i2c_req && ((sel == 2'b01) || sel[1]);
  assign gnt_req  = (gnt_q == PORT_I2C) ? i2c_req : spi_req;
  assign gnt_ack  = (gnt_q == PORT_I2C) ? i2c_ack_q : spi_ack_q;
  assign idx      = addr_q[IDX_W-1:0];

  // Unmapped indices in either bank read back as zero.
  always_comb begin
    rd_val = '0;
    if (!addr_q[ADDR_WIDTH-1]) begin
      for (int k = 0; k < CFG_VIS; k++) begin
        if (idx == IDX_W'(k)) rd_val = cfg_q[k];
      end
    end else begin
      for (int k = 0; k < ST_VIS; k++) begin
        if (idx == IDX_W'(k)) rd_val = status_regs[k*REG_WIDTH +: REG_WIDTH];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_last_d   = rr_last_q;
    gnt_d       = gnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    spi_ack_d   = spi_ack_q;
    i2c_ack_d   = i2c_ack_q;
    spi_rdata_d = spi_rdata_q;
    i2c_rdata_d = i2c_rdata_q;
    cfg_d       = cfg_q;

    case (state_q)
      ST_IDLE: begin
        if (spi_cand || i2c_cand) begin
          // Under contention the port that was not served last wins.
          if (spi_cand && i2c_cand) gnt_d = ~rr_last_q;
          else                      gnt_d = i2c_cand ? PORT_I2C : PORT_SPI;
          rr_last_d = gnt_d;
          we_d      = (gnt_d == PORT_I2C) ? i2c_we    : spi_we;
          addr_d    = (gnt_d == PORT_I2C) ? i2c_addr  : spi_addr;
          wdata_d   = (gnt_d == PORT_I2C) ? i2c_wdata : spi_wdata;
          state_d   = ST_ACCESS;
        end
      end

      ST_ACCESS: begin
        if (we_q) begin
          if (!addr_q[ADDR_WIDTH-1]) begin
            for (int k = 0; k < CFG_VIS; k++) begin
              if (idx == IDX_W'(k)) cfg_d[k] = wdata_q;
            end
          end
        end else if (gnt_q == PORT_I2C) begin
          i2c_rdata_d = rd_val;
        end else begin
          spi_rdata_d = rd_val;
        end
        state_d = ST_ACK;
      end

      ST_ACK: begin
        if (!gnt_ack) begin
          if (gnt_q == PORT_I2C) i2c_ack_d = 1'b1;
          else                   spi_ack_d = 1'b1;
        end else if (!gnt_req) begin
          spi_ack_d = 1'b0;
          i2c_ack_d = 1'b0;
          state_d   = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rr_last_q   <= PORT_I2C;
      gnt_q       <= PORT_SPI;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      spi_ack_q   <= 1'b0;
      i2c_ack_q   <= 1'b0;
      spi_rdata_q <= '0;
      i2c_rdata_q <= '0;
      for (int k = 0; k < NUM_CFG; k++) cfg_q[k] <= '0;
    end else if (ena) begin
      state_q     <= state_d;
      rr_last_q   <= rr_last_d;
      gnt_q       <= gnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      spi_ack_q   <= spi_ack_d;
      i2c_ack_q   <= i2c_ack_d;
      spi_rdata_q <= spi_rdata_d;
      i2c_rdata_q <= i2c_rdata_d;
      for (int k = 0; k < NUM_CFG; k++) cfg_q[k] <= cfg_d[k];
    end
  end

  generate
    for (genvar k = 0; k < NUM_CFG; k++) begin : g_cfg_out
      assign config_regs[k*REG_WIDTH +: REG_WIDTH] = cfg_q[k];
    end
  endgenerate

  assign spi_ack   = spi_ack_q;
  assign i2c_ack   = i2c_ack_q;
  assign spi_rdata = spi_rdata_q;
  assign i2c_rdata = i2c_rdata_q;
  assign busy      = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_reg_bank_arbiter.sv
`default_nettype none
// tb_reg_bank_arbiter: directed vector table, multi-cycle corner sequences and
// randomized arbitration rounds checked against a transaction-level model.
module tb_reg_bank_arbiter;

  localparam int NC = 8;
  localparam int NS = 8;
  localparam int W  = 8;
  localparam int AW = 4;
  localparam logic [NS*W-1:0] ST_FIX = {8'h5A, 8'h66, 8'h55, 8'h44, 8'h33, 8'hAA, 8'h11, 8'hCA};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, ena;
  logic [1:0]    sel;
  logic          spi_req, spi_we, spi_ack;
  logic [AW-1:0] spi_addr;
  logic [W-1:0]  spi_wdata, spi_rdata;
  logic          i2c_req, i2c_we, i2c_ack;
  logic [AW-1:0] i2c_addr;
  logic [W-1:0]  i2c_wdata, i2c_rdata;
  logic [NS*W-1:0] status_regs;
  logic [NC*W-1:0] config_regs;
  logic          busy;

  reg_bank_arbiter #(.NUM_CFG(NC), .NUM_STATUS(NS), .REG_WIDTH(W), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .sel(sel),
    .spi_req(spi_req), .spi_we(spi_we), .spi_addr(spi_addr), .spi_wdata(spi_wdata),
    .spi_ack(spi_ack), .spi_rdata(spi_rdata),
    .i2c_req(i2c_req), .i2c_we(i2c_we), .i2c_addr(i2c_addr), .i2c_wdata(i2c_wdata),
    .i2c_ack(i2c_ack), .i2c_rdata(i2c_rdata),
    .status_regs(status_regs), .config_regs(config_regs), .busy(busy)
  );

  typedef struct {
    logic [1:0] sel;
    logic       port;
    logic       we;
    logic [3:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rd;
  } vec_t;

  vec_t tbl [15];

  int total = 0;
  int bad   = 0;

  // Transaction-level model: config bank contents and last served port (0=SPI, 1=I2C).
  logic [NC*W-1:0] m_cfg;
  logic            m_rr;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] m_read(input logic [3:0] a);
    if (!a[3]) return m_cfg[a[2:0]*8 +: 8];
    return status_regs[a[2:0]*8 +: 8];
  endfunction

  task automatic m_write(input logic [3:0] a, input logic [7:0] d);
    if (!a[3]) m_cfg[a[2:0]*8 +: 8] = d;
  endtask

  function automatic logic ack_of(input logic p);
    return p ? i2c_ack : spi_ack;
  endfunction

  function automatic logic [7:0] rdata_of(input logic p);
    return p ? i2c_rdata : spi_rdata;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic p, input logic req, input logic we, input logic [3:0] a,
                       input logic [7:0] d);
    if (!p) begin
      spi_req = req; spi_we = we; spi_addr = a; spi_wdata = d;
    end else begin
      i2c_req = req; i2c_we = we; i2c_addr = a; i2c_wdata = d;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; ena = 1'b1; sel = 2'b00;
    drive(1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
    drive(1'b1, 1'b0, 1'b0, 4'h0, 8'h00);
    status_regs = ST_FIX;
    tick();
    tick();
    rst_n = 1'b1;
    m_cfg = '0;
    m_rr  = 1'b1;
  endtask

  task automatic wait_ack(output int cyc, output logic who);
    cyc = 0;
    who = 1'b0;
    while (cyc < 10) begin
      tick();
      cyc++;
      if (spi_ack || i2c_ack) begin
        who = i2c_ack;
        return;
      end
    end
    total++;
    bad++;
    $display("FAIL ack_timeout: got no ack want ack within 10 cycles");
  endtask

  // Single transaction from an idle arbiter, checking exact cycle timing.
  task automatic txn(input logic p, input logic we, input logic [3:0] a, input logic [7:0] d,
                     input logic [7:0] exp_rd, input string nm);
    drive(p, 1'b1, we, a, d);
    tick();
    check({nm, " ack_edgeN"}, ack_of(p), 1'b0);
    check({nm, " busy"}, busy, 1'b1);
    tick();
    check({nm, " ack_edgeN1"}, ack_of(p), 1'b0);
    tick();
    check({nm, " ack_edgeN2"}, ack_of(p), 1'b1);
    check({nm, " other_ack"}, ack_of(!p), 1'b0);
    if (!we) check({nm, " rdata"}, rdata_of(p), exp_rd);
    else     m_write(a, d);
    m_rr = p;
    drive(p, 1'b0, we, a, d);
    tick();
    check({nm, " ack_drop"}, ack_of(p), 1'b0);
    check({nm, " busy_idle"}, busy, 1'b0);
    check({nm, " config"}, config_regs, m_cfg);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish want finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int   cyc;
    logic who;
    int   frz;

    tbl = '{
      '{2'b00, 1'b0, 1'b1, 4'h2, 8'hA5, 8'h00},
      '{2'b00, 1'b0, 1'b0, 4'h2, 8'h00, 8'hA5},
      '{2'b00, 1'b0, 1'b0, 4'h8, 8'h00, 8'hCA},
      '{2'b00, 1'b0, 1'b0, 4'hF, 8'h00, 8'h5A},
      '{2'b00, 1'b0, 1'b1, 4'h7, 8'h3C, 8'h00},
      '{2'b00, 1'b0, 1'b0, 4'h7, 8'h00, 8'h3C},
      '{2'b00, 1'b0, 1'b1, 4'hA, 8'h77, 8'h00},
      '{2'b00, 1'b0, 1'b0, 4'hA, 8'h00, 8'hAA},
      '{2'b01, 1'b1, 1'b1, 4'h0, 8'h11, 8'h00},
      '{2'b01, 1'b1, 1'b0, 4'h0, 8'h00, 8'h11},
      '{2'b01, 1'b1, 1'b0, 4'h2, 8'h00, 8'hA5},
      '{2'b10, 1'b1, 1'b0, 4'h7, 8'h00, 8'h3C},
      '{2'b11, 1'b0, 1'b0, 4'h5, 8'h00, 8'h00},
      '{2'b10, 1'b0, 1'b1, 4'h5, 8'hC3, 8'h00},
      '{2'b11, 1'b1, 1'b0, 4'h5, 8'h00, 8'hC3}
    };

    // Reset state
    do_reset();
    check("reset config", config_regs, 64'h0);
    check("reset acks", {spi_ack, i2c_ack}, 2'b00);
    check("reset rdata", {spi_rdata, i2c_rdata}, 16'h0);
    check("reset busy", busy, 1'b0);

    // Directed vector table
    for (int i = 0; i < 15; i++) begin
      sel = tbl[i].sel;
      txn(tbl[i].port, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].exp_rd,
          $sformatf("vec%0d", i));
    end

    // Round-robin under contention
    do_reset();
    sel = 2'b10;
    drive(1'b0, 1'b1, 1'b0, 4'h8, 8'h00);
    drive(1'b1, 1'b1, 1'b0, 4'hF, 8'h00);
    wait_ack(cyc, who);
    check("arb1 latency", cyc, 3);
    check("arb1 winner", who, 1'b0);
    check("arb1 rdata", spi_rdata, 8'hCA);
    drive(1'b0, 1'b0, 1'b0, 4'h8, 8'h00);
    tick();
    check("arb1 ack_drop", spi_ack, 1'b0);
    wait_ack(cyc, who);
    check("arb2 latency", cyc, 3);
    check("arb2 winner", who, 1'b1);
    check("arb2 rdata", i2c_rdata, 8'h5A);
    check("arb2 spi_rdata_hold", spi_rdata, 8'hCA);
    drive(1'b1, 1'b0, 1'b0, 4'hF, 8'h00);
    tick();
    drive(1'b0, 1'b1, 1'b0, 4'h9, 8'h00);
    wait_ack(cyc, who);
    check("arb3 winner", who, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 4'h9, 8'h00);
    tick();
    drive(1'b0, 1'b1, 1'b0, 4'h8, 8'h00);
    drive(1'b1, 1'b1, 1'b0, 4'hA, 8'h00);
    wait_ack(cyc, who);
    check("arb4 winner", who, 1'b1);
    check("arb4 rdata", i2c_rdata, 8'hAA);
    drive(1'b1, 1'b0, 1'b0, 4'hA, 8'h00);
    tick();
    wait_ack(cyc, who);
    check("arb5 winner", who, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 4'h8, 8'h00);
    tick();

    // Ineligible request stays pending until sel allows it
    sel = 2'b01;
    drive(1'b0, 1'b1, 1'b1, 4'h3, 8'h9E);
    frz = 0;
    repeat (20) begin
      tick();
      if (spi_ack !== 1'b0 || busy !== 1'b0) frz++;
    end
    check("inelig no_service", frz, 0);
    check("inelig config", config_regs, m_cfg);
    sel = 2'b00;
    wait_ack(cyc, who);
    check("inelig served", who, 1'b0);
    m_write(4'h3, 8'h9E);
    drive(1'b0, 1'b0, 1'b1, 4'h3, 8'h9E);
    tick();
    check("inelig config_after", config_regs, m_cfg);

    // Clock enable low freezes an acknowledged transaction
    drive(1'b0, 1'b1, 1'b0, 4'h8, 8'h00);
    wait_ack(cyc, who);
    ena = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 4'h8, 8'h00);
    frz = 0;
    repeat (5) begin
      tick();
      if (spi_ack !== 1'b1 || spi_rdata !== 8'hCA || busy !== 1'b1) frz++;
    end
    check("ena frozen", frz, 0);
    ena = 1'b1;
    tick();
    check("ena resume ack", spi_ack, 1'b0);
    check("ena resume busy", busy, 1'b0);

    // Reset during ACCESS of a write: no partial write
    drive(1'b0, 1'b1, 1'b1, 4'h0, 8'hFF);
    tick();
    check("rstacc busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rstacc config", config_regs, 64'h0);
    check("rstacc acks", {spi_ack, i2c_ack, busy}, 3'b000);
    drive(1'b0, 1'b0, 1'b1, 4'h0, 8'hFF);
    tick();
    rst_n = 1'b1;
    tick();
    check("rstacc no_write", config_regs, 64'h0);

    // Reset during ACK drops the acknowledge immediately
    drive(1'b0, 1'b1, 1'b0, 4'h8, 8'h00);
    wait_ack(cyc, who);
    #2;
    rst_n = 1'b0;
    #1;
    check("rstack ack", spi_ack, 1'b0);
    check("rstack rdata", spi_rdata, 8'h00);
    drive(1'b0, 1'b0, 1'b0, 4'h8, 8'h00);
    tick();
    rst_n = 1'b1;

    // Randomized rounds against the model
    do_reset();
    for (int r = 0; r < 200; r++) begin
      logic [1:0] s;
      logic       ws, wi, e_spi, e_i2c, win;
      logic       s_we, i_we;
      logic [3:0] s_a, i_a;
      logic [7:0] s_d, i_d, exp_rd;
      s    = 2'($urandom_range(0, 3));
      ws   = 1'($urandom_range(0, 1));
      wi   = 1'($urandom_range(0, 1));
      s_we = 1'($urandom_range(0, 1));
      i_we = 1'($urandom_range(0, 1));
      s_a  = 4'($urandom_range(0, 15));
      i_a  = 4'($urandom_range(0, 15));
      s_d  = 8'($urandom_range(0, 255));
      i_d  = 8'($urandom_range(0, 255));
      status_regs = {$urandom, $urandom};
      sel = s;
      e_spi = ws && (s == 2'b00 || s[1]);
      e_i2c = wi && (s == 2'b01 || s[1]);
      drive(1'b0, ws, s_we, s_a, s_d);
      drive(1'b1, wi, i_we, i_a, i_d);
      if (!e_spi && !e_i2c) begin
        repeat (3) tick();
        check($sformatf("rnd%0d idle", r), {spi_ack, i2c_ack, busy}, 3'b000);
        drive(1'b0, 1'b0, s_we, s_a, s_d);
        drive(1'b1, 1'b0, i_we, i_a, i_d);
        tick();
        continue;
      end
      win    = (e_spi && e_i2c) ? !m_rr : e_i2c;
      exp_rd = m_read(win ? i_a : s_a);
      wait_ack(cyc, who);
      check($sformatf("rnd%0d latency", r), cyc, 3);
      check($sformatf("rnd%0d winner", r), who, win);
      check($sformatf("rnd%0d acks", r), {spi_ack, i2c_ack}, win ? 2'b01 : 2'b10);
      if (!(win ? i_we : s_we)) check($sformatf("rnd%0d rdata", r), rdata_of(win), exp_rd);
      else m_write(win ? i_a : s_a, win ? i_d : s_d);
      m_rr = win;
      drive(1'b0, 1'b0, s_we, s_a, s_d);
      drive(1'b1, 1'b0, i_we, i_a, i_d);
      tick();
      check($sformatf("rnd%0d done", r), {spi_ack, i2c_ack, busy}, 3'b000);
      check($sformatf("rnd%0d config", r), config_regs, m_cfg);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
